// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch and sequencing stage upstream of the instruction decoder.
// Owns the PC, fetches over the instruction-memory port, holds the fetched
// word for the decoder, then uses the decoder's outputs to sequence an
// optional data-memory access and compute the next PC. A one-cycle commit
// pulse marks instruction retirement and gates register-file writes.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   RST        in   1   synchronous active-high reset
//   ihit       in   1   instruction memory returns iload this cycle
//   iload      in  32   instruction word from memory
//   iREN       out  1   instruction read request (FETCH only)
//   iaddr      out 32   instruction address (= pc)
//   instr      out 32   held instruction, fed to decoder
//   pc_plus4   out 32   pc + 4 (JAL link value)
//   Jump       in   2   00 seq/branch, 01 JR, 10 J, 11 JAL
//   Branch     in   1   decoder branch flag
//   bne        in   1   1 = branch on not-equal, 0 = branch on equal
//   zero       in   1   ALU zero flag
//   jr_target  in  32   rs register value for JR
//   dREN_in    in   1   decoder data read
//   dWEN_in    in   1   decoder data write
//   halt_in    in   1   decoder halt
//   dhit       in   1   data memory completes access
//   dREN       out  1   data read request to memory
//   dWEN       out  1   data write request to memory
//   commit     out  1   instruction retires this cycle
//   halt       out  1   sticky halted flag
//   icount     out 32   retired-instruction counter (only with INSTR_COUNT_EN)
//
// Build option: define INSTR_COUNT_EN to add the icount output and counter.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  Jump,
   input  logic        Branch,
   input  logic        bne,
   input  logic        zero,
   input  logic [31:0] jr_target,
   input  logic        dREN_in,
   input  logic        dWEN_in,
   input  logic        halt_in,
   input  logic        dhit,
   output logic        dREN,
   output logic        dWEN,
   output logic        commit,
   output logic        halt
`ifdef INSTR_COUNT_EN
   ,
   output logic [31:0] icount
`endif
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_MEM    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_dren;
   logic        r_dwen;

   logic        w_iren;
   logic        w_commit;
   logic        w_instr_load;
   logic        w_dreq_load;
   logic        w_dreq_clear;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_offset;
   logic        w_br_taken;
   logic [31:0] w_next_pc;

   // JR targets are forced word-aligned, so the two low bits are never used.
   logic        w_unused;
   assign w_unused = ^jr_target[1:0];

   // ---------------------------------------------------------------------
   // Next-PC computation (all adds wrap mod 2^32 naturally)
   // ---------------------------------------------------------------------
   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_br_taken  = Branch & (zero ^ bne);

   // Jump select takes priority over Branch: Branch only matters for 2'b00.
   always_comb begin
      w_next_pc = w_pc_plus4;
      case (Jump)
         2'b00:   w_next_pc = w_br_taken ? (w_pc_plus4 + w_br_offset) : w_pc_plus4;
         2'b01:   w_next_pc = {jr_target[31:2], 2'b00};
         default: w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_iren       = 1'b0;
      w_commit     = 1'b0;
      w_instr_load = 1'b0;
      w_dreq_load  = 1'b0;
      w_dreq_clear = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_iren = 1'b1;
            if (ihit) begin
               w_instr_load = 1'b1;
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            // Halt wins over a simultaneous data request.
            if (halt_in) begin
               w_state_next = S_HALTED;
            end else if (dREN_in | dWEN_in) begin
               w_dreq_load  = 1'b1;
               w_state_next = S_MEM;
            end else begin
               w_commit     = 1'b1;
               w_state_next = S_FETCH;
            end
         end
         S_MEM: begin
            if (dhit) begin
               w_commit     = 1'b1;
               w_dreq_clear = 1'b1;
               w_state_next = S_FETCH;
            end
         end
         S_HALTED: begin
            w_state_next = S_HALTED;
         end
         default: begin
            w_state_next = S_FETCH;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc    <= PC_INIT;
         r_instr <= 32'd0;
         r_dren  <= 1'b0;
         r_dwen  <= 1'b0;
      end else begin
         if (w_instr_load) begin
            r_instr <= iload;
         end
         if (w_commit) begin
            r_pc <= w_next_pc;
         end
         // Data requests are captured on entry to MEM and held until dhit.
         if (w_dreq_load) begin
            r_dren <= dREN_in;
            r_dwen <= dWEN_in;
         end else if (w_dreq_clear) begin
            r_dren <= 1'b0;
            r_dwen <= 1'b0;
         end
      end
   end

`ifdef INSTR_COUNT_EN
   logic [31:0] r_icount;

   // No commits occur in HALTED, so the counter freezes there by construction.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_icount <= 32'd0;
      end else if (w_commit) begin
         r_icount <= r_icount + 32'd1;
      end
   end

   assign icount = r_icount;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign iREN     = w_iren;
   assign iaddr    = r_pc;
   assign instr    = r_instr;
   assign pc_plus4 = w_pc_plus4;
   assign dREN     = r_dren;
   assign dWEN     = r_dwen;
   assign commit   = w_commit;
   assign halt     = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer (PC_INIT = 0x100). Directed steps
// cover the reset state, branch/jump arithmetic, data-memory stalls, reset
// during a memory access, halt and PC wrap; a randomized run of instructions
// follows, checked against an instruction-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_sequencer;

   localparam logic [31:0] PCI = 32'h0000_0100;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] iload = 32'd0;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic [1:0]  Jump = 2'b00;
   logic        Branch = 1'b0;
   logic        bne = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] jr_target = 32'd0;
   logic        dREN_in = 1'b0;
   logic        dWEN_in = 1'b0;
   logic        halt_in = 1'b0;
   logic        dhit = 1'b0;
   logic        dREN;
   logic        dWEN;
   logic        commit;
   logic        halt;
`ifdef INSTR_COUNT_EN
   logic [31:0] icount;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_pc;
   logic [31:0] m_count;

   fetch_sequencer #(.PC_INIT(PCI)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ihit      (ihit),
      .iload     (iload),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .instr     (instr),
      .pc_plus4  (pc_plus4),
      .Jump      (Jump),
      .Branch    (Branch),
      .bne       (bne),
      .zero      (zero),
      .jr_target (jr_target),
      .dREN_in   (dREN_in),
      .dWEN_in   (dWEN_in),
      .halt_in   (halt_in),
      .dhit      (dhit),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .commit    (commit),
      .halt      (halt)
`ifdef INSTR_COUNT_EN
      ,
      .icount    (icount)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference next-PC, written from the instruction-set rules.
   function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] iw,
                                               input logic [1:0] j, input logic br,
                                               input logic bn, input logic z,
                                               input logic [31:0] jr);
      int          off;
      logic [31:0] nxt;
      nxt = pc + 32'd4;
      if (j == 2'b01) begin
         nxt = jr & ~32'd3;
      end else if (j != 2'b00) begin
         nxt = ((pc + 32'd4) & 32'hF000_0000) | (32'(iw[25:0]) * 32'd4);
      end else if (br && (bn ? !z : z)) begin
         off = int'(iw[15:0]);
         if (off >= 32768) off = off - 65536;
         nxt = pc + 32'd4 + 32'(off * 4);
      end
      return nxt;
   endfunction

   task automatic idle_decoder();
      Jump = 2'($urandom); Branch = 1'($urandom); bne = 1'($urandom);
      zero = 1'($urandom); jr_target = $urandom; dREN_in = 1'($urandom);
      dWEN_in = 1'($urandom); halt_in = 1'($urandom);
   endtask

   task automatic check_fetch(input string tag);
      chk({tag, "_iREN"}, 32'(iREN), 32'd1);
      chk({tag, "_iaddr"}, iaddr, m_pc);
      chk({tag, "_commit"}, 32'(commit), 32'd0);
      chk({tag, "_dREN"}, 32'(dREN), 32'd0);
      chk({tag, "_dWEN"}, 32'(dWEN), 32'd0);
      chk({tag, "_halt"}, 32'(halt), 32'd0);
`ifdef INSTR_COUNT_EN
      chk({tag, "_icount"}, icount, m_count);
`endif
   endtask

   // One complete instruction: FETCH (with fwait idle cycles), EXEC and,
   // for loads/stores, MEM with mwait cycles before dhit.
   task automatic run_instr(input logic [31:0] iw, input logic [1:0] j, input logic br,
                            input logic bn, input logic z, input logic [31:0] jr,
                            input logic rd, input logic wr, input int fwait, input int mwait);
      logic [31:0] exp_next;
      for (int k = 0; k < fwait; k++) begin
         ihit = 1'b0; iload = $urandom; dhit = 1'($urandom); idle_decoder();
         #1 check_fetch("fetch_wait");
         tick();
      end
      ihit = 1'b1; iload = iw; dhit = 1'($urandom); idle_decoder();
      #1 check_fetch("fetch_hit");
      $display("instr pc=%h iw=%h jump=%b br=%b rd=%b wr=%b", m_pc, iw, j, br, rd, wr);
      tick();
      // EXEC: ihit/dhit here must be ignored
      ihit = 1'($urandom); iload = $urandom; dhit = 1'($urandom);
      Jump = j; Branch = br; bne = bn; zero = z; jr_target = jr;
      dREN_in = rd; dWEN_in = wr; halt_in = 1'b0;
      exp_next = ref_next_pc(m_pc, iw, j, br, bn, z, jr);
      #1;
      chk("exec_instr", instr, iw);
      chk("exec_iREN", 32'(iREN), 32'd0);
      chk("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("exec_commit", 32'(commit), 32'((rd | wr) ? 1'b0 : 1'b1));
      chk("exec_dREN", 32'(dREN), 32'd0);
      tick();
      if (rd | wr) begin
         for (int k = 0; k < mwait; k++) begin
            dhit = 1'b0; ihit = 1'($urandom);
            #1;
            chk("mem_dREN", 32'(dREN), 32'(rd));
            chk("mem_dWEN", 32'(dWEN), 32'(wr));
            chk("mem_commit", 32'(commit), 32'd0);
            chk("mem_iREN", 32'(iREN), 32'd0);
            tick();
         end
         dhit = 1'b1;
         #1;
         chk("dhit_dREN", 32'(dREN), 32'(rd));
         chk("dhit_dWEN", 32'(dWEN), 32'(wr));
         chk("dhit_commit", 32'(commit), 32'd1);
         tick();
         dhit = 1'b0;
      end
      m_pc    = exp_next;
      m_count = m_count + 32'd1;
   endtask

   task automatic do_reset();
      RST = 1'b1; ihit = 1'b1; iload = $urandom; dhit = 1'b1;
      tick();
      RST = 1'b0; ihit = 1'b0; dhit = 1'b0;
      m_pc = PCI; m_count = 32'd0;
   endtask

   initial begin
      logic [31:0] iw;
      int          cls;
      logic [1:0]  rj;
      logic        rbr, rrd, rwr;

      // Reset state
      do_reset();
      #1;
      chk("rst_iaddr", iaddr, 32'h0000_0100);
      chk("rst_instr", instr, 32'd0);
      chk("rst_iREN", 32'(iREN), 32'd1);
      chk("rst_dREN", 32'(dREN), 32'd0);
      chk("rst_dWEN", 32'(dWEN), 32'd0);
      chk("rst_commit", 32'(commit), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      tick();

      // ADDIU: two cycles per instruction, next address 0x104
      run_instr(32'h2401_0005, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
      chk("addiu_next", iaddr, 32'h0000_0104);

      // BEQ at 0x200 with imm=0xFFFF: taken loops to itself, not taken falls through
      run_instr(32'h0000_0008, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1, 0);
      run_instr(32'h1000_FFFF, 2'b00, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);
      chk("beq_taken", iaddr, 32'h0000_0200);
      run_instr(32'h1000_FFFF, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
      chk("beq_not_taken", iaddr, 32'h0000_0204);

      // J from 0x4000_0010 and misaligned JR
      run_instr(32'h0000_0008, 2'b01, 1'b0, 1'b0, 1'b0, 32'h4000_0010, 1'b0, 1'b0, 0, 0);
      run_instr({6'h02, 26'h000_ABC0}, 2'b10, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);
      chk("j_target", iaddr, 32'h4002_AF00);
      run_instr(32'h0000_0008, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_1233, 1'b0, 1'b0, 0, 0);
      chk("jr_target", iaddr, 32'h0000_1230);

      // LW with dREN held three cycles, commit on the dhit cycle
      run_instr(32'h8C01_0000, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 0, 2);
      chk("lw_next", iaddr, 32'h0000_1234);

      // PC wrap
      run_instr(32'h0000_0008, 2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);
      chk("jr_top", iaddr, 32'hFFFF_FFFC);
      run_instr(32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
      chk("pc_wrap", iaddr, 32'h0000_0000);

      // Randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         cls = int'($urandom_range(0, 7));
         iw = $urandom;
         rj = 2'b00; rbr = 1'b0; rrd = 1'b0; rwr = 1'b0;
         case (cls)
            1: rbr = 1'b1;
            2: rj = 2'b10;
            3: rj = 2'b11;
            4: rj = 2'b01;
            5: rrd = 1'b1;
            6: rwr = 1'b1;
            7: begin rj = 2'($urandom_range(1, 3)); rbr = 1'b1; end
            default: ;
         endcase
         run_instr(iw, rj, rbr, 1'($urandom), 1'($urandom), $urandom, rrd, rwr,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
      #1 check_fetch("rand_end");

      // Reset while a load is outstanding in MEM
      ihit = 1'b1; iload = 32'h8C02_0004; idle_decoder();
      tick();
      Jump = 2'b00; Branch = 1'b0; dREN_in = 1'b1; dWEN_in = 1'b0; halt_in = 1'b0; ihit = 1'b0;
      tick();
      dhit = 1'b0;
      #1 chk("mem_before_rst_dREN", 32'(dREN), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      m_pc = PCI; m_count = 32'd0;
      #1;
      chk("rst_mem_dREN", 32'(dREN), 32'd0);
      chk("rst_mem_iaddr", iaddr, 32'h0000_0100);
      chk("rst_mem_instr", instr, 32'd0);
      chk("rst_mem_iREN", 32'(iREN), 32'd1);
      tick();

      // One retired instruction, then HALT together with a data write
      run_instr(32'h2401_0001, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
      ihit = 1'b1; iload = 32'hFC00_0000; idle_decoder();
      tick();
      Jump = 2'b00; Branch = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b1; halt_in = 1'b1; dhit = 1'b1;
      #1;
      chk("halt_exec_commit", 32'(commit), 32'd0);
      chk("halt_exec_dWEN", 32'(dWEN), 32'd0);
      chk("halt_exec_iREN", 32'(iREN), 32'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         ihit = 1'b1; iload = $urandom; dhit = 1'($urandom); idle_decoder();
         #1;
         chk("halted_halt", 32'(halt), 32'd1);
         chk("halted_iREN", 32'(iREN), 32'd0);
         chk("halted_dWEN", 32'(dWEN), 32'd0);
         chk("halted_dREN", 32'(dREN), 32'd0);
         chk("halted_commit", 32'(commit), 32'd0);
         chk("halted_iaddr", iaddr, m_pc);
`ifdef INSTR_COUNT_EN
         chk("halted_icount", icount, m_count);
`endif
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
